// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 shift-add multiply / 8/8 restoring divide sequencer.
// Drives the shared combinational ALU one step per EXEC cycle.
module alu_muldiv_seq #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] DZ_QUOT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             dz_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_fs,
    output logic             alu_ci,
    input  logic [WIDTH-1:0] alu_f,
    input  logic [3:0]       alu_status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [2:0] FS_ADD = 3'b010;
    localparam logic [2:0] FS_SUB = 3'b011;

    state_t           state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             cbit_q, cbit_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic             dz_q, dz_d;
    logic             carry;
    logic             unused_status;

    assign carry         = alu_status[2];
    assign unused_status = ^{alu_status[3], alu_status[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cbit_q   <= 1'b0;
            op_q     <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cbit_q   <= cbit_d;
            op_q     <= op_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        cbit_d   = cbit_q;
        op_d     = op_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    hi_d    = '0;
                    cbit_d  = 1'b0;
                    count_d = '0;
                    dz_d    = 1'b0;
                    if (op) begin
                        opnd_d = opb;
                        lo_d   = opa;
                        if (opb == '0) begin
                            state_d  = S_DONE;
                            res_hi_d = opa;
                            res_lo_d = DZ_QUOT;
                            dz_d     = 1'b1;
                        end else begin
                            state_d = S_SHIFT;
                        end
                    end else begin
                        opnd_d  = opa;
                        lo_d    = opb;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (!op_q) begin
                    hi_d    = alu_f;
                    cbit_d  = carry;
                    state_d = S_SHIFT;
                end else begin
                    // Remainder bit 8 or no borrow: keep the difference.
                    if (cbit_q | carry) begin
                        hi_d    = alu_f;
                        lo_d[0] = 1'b1;
                    end else begin
                        lo_d[0] = 1'b0;
                    end
                    count_d = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_d  = S_DONE;
                        res_hi_d = hi_d;
                        res_lo_d = lo_d;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                if (!op_q) begin
                    {hi_d, lo_d} = {cbit_q, hi_q, lo_q[WIDTH-1:1]};
                    count_d      = count_q + 3'd1;
                    if (count_q == 3'd7) begin
                        state_d  = S_DONE;
                        res_hi_d = hi_d;
                        res_lo_d = lo_d;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    {cbit_d, hi_d, lo_d} = {hi_q, lo_q, 1'b0};
                    state_d              = S_EXEC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_fs = 3'b000;
        alu_ci = 1'b0;
        if (state_q == S_EXEC) begin
            alu_a = hi_q;
            if (op_q) begin
                alu_b  = opnd_q;
                alu_fs = FS_SUB;
                alu_ci = 1'b1;
            end else begin
                alu_b  = lo_q[0] ? opnd_q : '0;
                alu_fs = FS_ADD;
            end
        end
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        result_hi = res_hi_q;
        result_lo = res_lo_q;
        dz_err    = dz_q;
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: behavioural ALU plus arithmetic reference
// model, directed corner cases followed by random operations.
module tb_alu_muldiv_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       op;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       busy;
    logic       done;
    logic [7:0] result_hi;
    logic [7:0] result_lo;
    logic       dz_err;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_fs;
    logic       alu_ci;
    logic [7:0] alu_f;
    logic [3:0] alu_status;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_seq dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .opa(opa),
        .opb(opb),
        .busy(busy),
        .done(done),
        .result_hi(result_hi),
        .result_lo(result_lo),
        .dz_err(dz_err),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_fs(alu_fs),
        .alu_ci(alu_ci),
        .alu_f(alu_f),
        .alu_status(alu_status)
    );

    // Combinational 8-bit ALU: ADD a+b+ci, SUB a+~b+ci; status {V,C,N,Z}.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum = 9'd0;
        case (alu_fs)
            3'b010:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_ci};
            3'b011:  alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_ci};
            default: alu_sum = {1'b0, alu_a};
        endcase
        alu_f      = alu_sum[7:0];
        alu_status = {1'b0, alu_sum[8], alu_sum[7], alu_sum[7:0] == 8'd0};
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_res"}, {16'd0, result_hi, result_lo}, 32'd0);
        chk({tag, "_dz"}, {31'd0, dz_err}, 32'd0);
        chk({tag, "_alu"}, {12'd0, alu_a, alu_b, alu_fs, alu_ci}, 32'd0);
    endtask

    // kick > 0 re-pulses start with other operands in that busy cycle.
    task automatic run_op(input logic o, input logic [7:0] a,
                          input logic [7:0] b, input int kick);
        logic [15:0] exp;
        logic        ez;
        int          lat;
        int          c;
        if (o && b == 8'd0) begin
            exp = {a, 8'hFF};
            ez  = 1'b1;
            lat = 1;
        end else if (o) begin
            exp = {a % b, a / b};
            ez  = 1'b0;
            lat = 17;
        end else begin
            exp = 16'(a * b);
            ez  = 1'b0;
            lat = 17;
        end
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        opa   = 8'($urandom);
        opb   = 8'($urandom);
        c     = 1;
        chk("busy_c1", {31'd0, busy}, 32'd1);
        while (!done && c < 40) begin
            if (c == kick) begin
                start = 1'b1;
                op    = 1'b0;
                opa   = 8'd200;
                opb   = 8'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
        chk("latency", c, lat);
        chk("result", {16'd0, result_hi, result_lo}, {16'd0, exp});
        chk("dz_err", {31'd0, dz_err}, {31'd0, ez});
        chk("alu_idle_done", {12'd0, alu_a, alu_b, alu_fs, alu_ci}, 32'd0);
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        chk("hold", {16'd0, result_hi, result_lo}, {16'd0, exp});
        chk("dz_hold", {31'd0, dz_err}, {31'd0, ez});
    endtask

    initial begin
        logic       ro;
        logic [7:0] ra;
        logic [7:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        op    = 1'b0;
        opa   = 8'd0;
        opb   = 8'd0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(1'b0, 8'd13, 8'd11, 0);
        run_op(1'b0, 8'd255, 8'd255, 0);
        run_op(1'b0, 8'd0, 8'd200, 0);
        run_op(1'b1, 8'd200, 8'd7, 0);
        run_op(1'b1, 8'd7, 8'd200, 0);
        run_op(1'b1, 8'd255, 8'd1, 0);
        run_op(1'b1, 8'd77, 8'd0, 0);
        run_op(1'b0, 8'd3, 8'd5, 0);
        run_op(1'b0, 8'd13, 8'd11, 5);

        // Abort a divide part way through.
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        opa   = 8'd77;
        opb   = 8'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_nodone", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b1, 8'd200, 8'd7, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(ro, ra, rb, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
